// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART command-frame serializer.
package uart_frame_pkg;

    // Serializer FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_B = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        GAP     = 3'd5
    } state_t;

    // Parity type encodings for the par_typ input.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bits on the line for one frame: start + payload + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_width, input logic par_en);
        return 32'd2 + data_width + (par_en ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Prescale down-counter: raises bit_end in the last cycle of every bit period.
// last_next flags that the following cycle will be the last of its bit period.
module uart_bit_tick #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_end,
    output logic                      last_next
);

    localparam logic [PRESCALE_WIDTH-1:0] CNT_ZERO = PRESCALE_WIDTH'(0);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] cnt_r;
    logic [PRESCALE_WIDTH-1:0] cnt_next_s;
    logic [PRESCALE_WIDTH-1:0] reload_s;

    // Reload value (prescale 0 behaves as 1) and next counter value.
    always_comb begin
        reload_s   = CNT_ZERO;
        cnt_next_s = CNT_ZERO;
        if (prescale == CNT_ZERO) begin
            reload_s = CNT_ZERO;
        end else begin
            reload_s = prescale - CNT_ONE;
        end
        if (!en || (cnt_r == CNT_ZERO)) begin
            cnt_next_s = reload_s;
        end else begin
            cnt_next_s = cnt_r - CNT_ONE;
        end
    end

    assign bit_end   = en && (cnt_r == CNT_ZERO);
    assign last_next = (cnt_next_s == CNT_ZERO);

    // Counter register; held at the reload value while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_gen.sv
// UART command-frame serializer: latches a multi-frame command and sends it as
// back-to-back UART frames (start, data LSB first, optional parity, stop) with
// an optional idle gap between frames.
module uart_cmd_frame_gen
    import uart_frame_pkg::*;
#(
    parameter int  DATA_WIDTH     = 8,
    parameter int  MAX_FRAMES     = 4,
    parameter int  PRESCALE_WIDTH = 6,
    parameter int  GAP_WIDTH      = 4,
    localparam int LEN_W          = $clog2(MAX_FRAMES + 1),
    localparam int IDX_W          = $clog2(MAX_FRAMES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [MAX_FRAMES*DATA_WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0]                 cmd_len,
    input  logic                             par_en,
    input  logic                             par_typ,
    input  logic [PRESCALE_WIDTH-1:0]        prescale,
    input  logic [GAP_WIDTH-1:0]             gap_bits,
    output logic                             tx_out,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             cmd_done,
    output logic [IDX_W-1:0]                 frame_idx
);

    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

    state_t                          state_r;
    logic [MAX_FRAMES*DATA_WIDTH-1:0] cmd_r;
    logic [LEN_W-1:0]                len_r;
    logic                            par_en_r;
    logic                            par_typ_r;
    logic [PRESCALE_WIDTH-1:0]       prescale_r;
    logic [GAP_WIDTH-1:0]            gap_r;
    logic [DATA_WIDTH-1:0]           shift_r;
    logic                            parity_r;
    logic [BC_W-1:0]                 bit_cnt_r;
    logic [GAP_WIDTH-1:0]            gap_cnt_r;
    logic [IDX_W-1:0]                frame_idx_r;
    logic                            tx_out_r;
    logic                            busy_r;
    logic                            frame_done_r;
    logic                            cmd_done_r;

    logic [PRESCALE_WIDTH-1:0]       prescale_s;
    logic [LEN_W-1:0]                len_clamp_s;
    logic [DATA_WIDTH-1:0]           frame_data_s;
    logic                            is_last_s;
    logic                            tick_en_s;
    logic                            bit_end_s;
    logic                            last_next_s;

    // Parity bit for one payload word.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

    // Timing source: live prescale while idle so the first bit already uses
    // the value being latched on accept.
    always_comb begin
        prescale_s  = prescale_r;
        len_clamp_s = cmd_len;
        if (state_r == IDLE) begin
            prescale_s = prescale;
        end else begin
            prescale_s = prescale_r;
        end
        if (cmd_len > LEN_W'(MAX_FRAMES)) begin
            len_clamp_s = LEN_W'(MAX_FRAMES);
        end else begin
            len_clamp_s = cmd_len;
        end
        frame_data_s = cmd_r[int'(frame_idx_r)*DATA_WIDTH +: DATA_WIDTH];
        is_last_s    = ((LEN_W'(frame_idx_r) + LEN_W'(1)) == len_r);
        tick_en_s    = (state_r != IDLE);
    end

    uart_bit_tick #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (tick_en_s),
        .prescale (prescale_s),
        .bit_end  (bit_end_s),
        .last_next(last_next_s)
    );

    // Serializer FSM with registered line and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cmd_r        <= {(MAX_FRAMES*DATA_WIDTH){1'b0}};
            len_r        <= {LEN_W{1'b0}};
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            prescale_r   <= {PRESCALE_WIDTH{1'b0}};
            gap_r        <= {GAP_WIDTH{1'b0}};
            shift_r      <= {DATA_WIDTH{1'b0}};
            parity_r     <= 1'b0;
            bit_cnt_r    <= {BC_W{1'b0}};
            gap_cnt_r    <= {GAP_WIDTH{1'b0}};
            frame_idx_r  <= {IDX_W{1'b0}};
            tx_out_r     <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            cmd_done_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            cmd_done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cmd_r       <= cmd_data;
                        len_r       <= len_clamp_s;
                        par_en_r    <= par_en;
                        par_typ_r   <= par_typ;
                        prescale_r  <= prescale;
                        gap_r       <= gap_bits;
                        frame_idx_r <= {IDX_W{1'b0}};
                        bit_cnt_r   <= {BC_W{1'b0}};
                        gap_cnt_r   <= {GAP_WIDTH{1'b0}};
                        if (len_clamp_s == LEN_W'(0)) begin
                            // Empty command completes at once without touching the line.
                            cmd_done_r <= 1'b1;
                        end else begin
                            state_r  <= START_B;
                            tx_out_r <= 1'b0;
                            busy_r   <= 1'b1;
                        end
                    end
                end
                START_B: begin
                    if (bit_end_s) begin
                        state_r   <= DATA;
                        tx_out_r  <= frame_data_s[0];
                        shift_r   <= frame_data_s >> 1;
                        parity_r  <= parity_bit(frame_data_s, par_typ_r);
                        bit_cnt_r <= {BC_W{1'b0}};
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= {BC_W{1'b0}};
                            if (par_en_r) begin
                                state_r  <= PARITY;
                                tx_out_r <= parity_r;
                            end else begin
                                state_r      <= STOP;
                                tx_out_r     <= 1'b1;
                                frame_done_r <= last_next_s;
                                cmd_done_r   <= last_next_s && is_last_s;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BC_W'(1);
                            tx_out_r  <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_r      <= STOP;
                        tx_out_r     <= 1'b1;
                        frame_done_r <= last_next_s;
                        cmd_done_r   <= last_next_s && is_last_s;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        if (is_last_s) begin
                            state_r  <= IDLE;
                            busy_r   <= 1'b0;
                            tx_out_r <= 1'b1;
                        end else if (gap_r != GAP_WIDTH'(0)) begin
                            state_r   <= GAP;
                            gap_cnt_r <= {GAP_WIDTH{1'b0}};
                            tx_out_r  <= 1'b1;
                        end else begin
                            state_r     <= START_B;
                            tx_out_r    <= 1'b0;
                            frame_idx_r <= frame_idx_r + IDX_W'(1);
                        end
                    end else begin
                        // Pulses land in the final cycle of the stop bit.
                        frame_done_r <= last_next_s;
                        cmd_done_r   <= last_next_s && is_last_s;
                    end
                end
                GAP: begin
                    if (bit_end_s) begin
                        if (gap_cnt_r == (gap_r - GAP_WIDTH'(1))) begin
                            state_r     <= START_B;
                            tx_out_r    <= 1'b0;
                            gap_cnt_r   <= {GAP_WIDTH{1'b0}};
                            frame_idx_r <= frame_idx_r + IDX_W'(1);
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GAP_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tx_out_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out     = tx_out_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign cmd_done   = cmd_done_r;
    assign frame_idx  = frame_idx_r;

endmodule

// File: tb/tb_uart_cmd_frame_gen.sv
// Directed testbench for uart_cmd_frame_gen: expected line waveforms are
// hand-written bit strings (one char per bit period) expanded by the prescale.
module tb_uart_cmd_frame_gen;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] cmd_data = 32'h0;
    logic [2:0]  cmd_len  = 3'd0;
    logic        par_en   = 1'b0;
    logic        par_typ  = 1'b0;
    logic [5:0]  prescale = 6'd0;
    logic [3:0]  gap_bits = 4'd0;
    logic        tx_out;
    logic        busy;
    logic        frame_done;
    logic        cmd_done;
    logic [1:0]  frame_idx;

    int checks   = 0;
    int failures = 0;

    uart_cmd_frame_gen #(
        .DATA_WIDTH(8), .MAX_FRAMES(4), .PRESCALE_WIDTH(6), .GAP_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_data(cmd_data),
        .cmd_len(cmd_len), .par_en(par_en), .par_typ(par_typ),
        .prescale(prescale), .gap_bits(gap_bits), .tx_out(tx_out),
        .busy(busy), .frame_done(frame_done), .cmd_done(cmd_done),
        .frame_idx(frame_idx)
    );

    always #5 clk = ~clk;

    // Repeat every char of s p times (per-cycle view of a per-bit string).
    function automatic string expand_tx(input string s, input int p);
        string r = "";
        for (int i = 0; i < s.len(); i++)
            for (int j = 0; j < p; j++) r = {r, s.substr(i, i)};
        return r;
    endfunction

    // Event markers occur only in the last cycle of their bit period.
    function automatic string expand_ev(input string m, input int p);
        string r = "";
        for (int i = 0; i < m.len(); i++) begin
            for (int j = 0; j < p - 1; j++) r = {r, "."};
            r = {r, m.substr(i, i)};
        end
        return r;
    endfunction

    // Drive a command at a negedge; it is accepted at the following posedge.
    task automatic launch(input logic [31:0] d, input logic [2:0] len, input logic pe,
                          input logic pt, input logic [5:0] ps, input logic [3:0] gb);
        cmd_data = d; cmd_len = len; par_en = pe; par_typ = pt;
        prescale = ps; gap_bits = gb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Record per-cycle outputs until the cmd_done cycle (or the bound runs out).
    task automatic capture(input int max_cyc, output string tx_s, output string ev_s,
                           output string busy_s, output string idx_s, output bit timed_out);
        tx_s = ""; ev_s = ""; busy_s = ""; idx_s = ""; timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            tx_s   = {tx_s, $sformatf("%0b", tx_out)};
            busy_s = {busy_s, $sformatf("%0b", busy)};
            idx_s  = {idx_s, $sformatf("%0d", frame_idx)};
            if (frame_done && cmd_done)  ev_s = {ev_s, "C"};
            else if (frame_done)         ev_s = {ev_s, "F"};
            else if (cmd_done)           ev_s = {ev_s, "D"};
            else                         ev_s = {ev_s, "."};
            if (cmd_done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 ||
            cmd_done !== 1'b0 || frame_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_values got tx=%b busy=%b fd=%b cd=%b idx=%0d exp tx=1 busy=0 fd=0 cd=0 idx=0",
                     tx_out, busy, frame_done, cmd_done, frame_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wr_even();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h0077_05AA, 3'd3, 1'b1, 1'b0, 6'd1, 4'd0);
        capture(100, tx_s, ev_s, busy_s, idx_s, to);
        checks++;
        if (to) begin failures++; $display("FAIL wr_timeout got=no cmd_done exp=cmd_done within 100 cycles"); end
        exp = expand_tx("001010101010101000000101110111001", 1);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL wr_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev("..........F..........F..........C", 1);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL wr_events got=%s exp=%s", ev_s, exp); end
        exp = expand_tx("000000000001111111111122222222222", 1);
        checks++;
        if (idx_s != exp) begin failures++; $display("FAIL wr_idx got=%s exp=%s", idx_s, exp); end
        exp = expand_tx("1", 33);
        checks++;
        if (busy_s != exp) begin failures++; $display("FAIL wr_busy got=%s exp=%s", busy_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1 || cmd_done !== 1'b0) begin
            failures++;
            $display("FAIL wr_after got busy=%b tx=%b cd=%b exp busy=0 tx=1 cd=0", busy, tx_out, cmd_done);
        end
    endtask

    task automatic test_alu_odd_gap();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h0000_01DD, 3'd2, 1'b1, 1'b1, 6'd8, 4'd2);
        capture(250, tx_s, ev_s, busy_s, idx_s, to);
        checks++;
        if (to) begin failures++; $display("FAIL alu_timeout got=no cmd_done exp=cmd_done within 250 cycles"); end
        exp = expand_tx("010111011111101000000001", 8);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL alu_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev("..........F............C", 8);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL alu_events got=%s exp=%s", ev_s, exp); end
        exp = expand_tx("000000000000011111111111", 8);
        checks++;
        if (idx_s != exp) begin failures++; $display("FAIL alu_idx got=%s exp=%s", idx_s, exp); end
        exp = expand_tx("1", 192);
        checks++;
        if (busy_s != exp) begin failures++; $display("FAIL alu_busy got=%s exp=%s", busy_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL alu_after got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out);
        end
    endtask

    task automatic test_no_parity();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'hDEAD_BE80, 3'd1, 1'b0, 1'b1, 6'd3, 4'd5);
        capture(60, tx_s, ev_s, busy_s, idx_s, to);
        checks++;
        if (to) begin failures++; $display("FAIL nopar_timeout got=no cmd_done exp=cmd_done within 60 cycles"); end
        checks++;
        if (ev_s.len() != 30) begin
            failures++;
            $display("FAIL nopar_done_latency got=%0d exp=30 cycles after accept", ev_s.len());
        end
        exp = expand_tx("0000000011", 3);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL nopar_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev(".........C", 3);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL nopar_events got=%s exp=%s", ev_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL nopar_after got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out);
        end
    endtask

    task automatic test_back_to_back();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h0000_000F, 3'd1, 1'b0, 1'b0, 6'd1, 4'd0);
        capture(30, tx_s, ev_s, busy_s, idx_s, to);
        exp = expand_tx("0111100001", 1);
        checks++;
        if (to || tx_s != exp) begin failures++; $display("FAIL b2b_first_tx got=%s exp=%s", tx_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy got=%b exp=0", busy); end
        launch(32'h0000_00F0, 3'd1, 1'b0, 1'b0, 6'd1, 4'd0);
        capture(30, tx_s, ev_s, busy_s, idx_s, to);
        exp = expand_tx("0000011111", 1);
        checks++;
        if (to || tx_s != exp) begin failures++; $display("FAIL b2b_second_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev(".........C", 1);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL b2b_second_events got=%s exp=%s", ev_s, exp); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h0000_C33C, 3'd2, 1'b0, 1'b0, 6'd2, 4'd1);
        fork
            capture(80, tx_s, ev_s, busy_s, idx_s, to);
            begin
                repeat (15) @(negedge clk);
                cmd_data = 32'hFFFF_FFFF; cmd_len = 3'd1; par_en = 1'b1; par_typ = 1'b1;
                prescale = 6'd1; gap_bits = 4'd0; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        checks++;
        if (to) begin failures++; $display("FAIL ign_timeout got=no cmd_done exp=cmd_done within 80 cycles"); end
        exp = expand_tx("000111100110110000111", 2);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL ign_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev(".........F..........C", 2);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL ign_events got=%s exp=%s", ev_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL ign_after got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out);
        end
    endtask

    task automatic test_len_zero();
        launch(32'h1234_5678, 3'd0, 1'b1, 1'b0, 6'd2, 4'd0);
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL len0_pulse got cd=%b busy=%b tx=%b fd=%b exp cd=1 busy=0 tx=1 fd=0",
                     cmd_done, busy, tx_out, frame_done);
        end
        @(negedge clk);
        checks++;
        if (cmd_done !== 1'b0 || busy !== 1'b0 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL len0_after got cd=%b busy=%b tx=%b exp cd=0 busy=0 tx=1", cmd_done, busy, tx_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h0000_5A55, 3'd2, 1'b1, 1'b0, 6'd4, 4'd0);
        repeat (52) @(negedge clk);
        checks++;
        if (frame_idx !== 2'd1 || busy !== 1'b1 || tx_out !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_before got idx=%0d busy=%b tx=%b exp idx=1 busy=1 tx=0", frame_idx, busy, tx_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || frame_idx !== 2'd0 || frame_done !== 1'b0 || cmd_done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got tx=%b busy=%b idx=%0d fd=%b cd=%b exp tx=1 busy=0 idx=0 fd=0 cd=0",
                     tx_out, busy, frame_idx, frame_done, cmd_done);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        launch(32'h0000_5A55, 3'd2, 1'b1, 1'b0, 6'd4, 4'd0);
        capture(120, tx_s, ev_s, busy_s, idx_s, to);
        checks++;
        if (to) begin failures++; $display("FAIL rstmid_timeout got=no cmd_done exp=cmd_done within 120 cycles"); end
        exp = expand_tx("0101010100100101101001", 4);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL rstmid_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev("..........F..........C", 4);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL rstmid_events got=%s exp=%s", ev_s, exp); end
        exp = expand_tx("0000000000011111111111", 4);
        checks++;
        if (idx_s != exp) begin failures++; $display("FAIL rstmid_idx got=%s exp=%s", idx_s, exp); end
        @(negedge clk);
    endtask

    task automatic test_clamp_prescale0();
        string tx_s, ev_s, busy_s, idx_s, exp;
        bit to;
        launch(32'h8844_2211, 3'd7, 1'b0, 1'b0, 6'd0, 4'd0);
        capture(80, tx_s, ev_s, busy_s, idx_s, to);
        checks++;
        if (to) begin failures++; $display("FAIL clamp_timeout got=no cmd_done exp=cmd_done within 80 cycles"); end
        exp = expand_tx("0100010001001000100100010001010000100011", 1);
        checks++;
        if (tx_s != exp) begin failures++; $display("FAIL clamp_tx got=%s exp=%s", tx_s, exp); end
        exp = expand_ev(".........F.........F.........F.........C", 1);
        checks++;
        if (ev_s != exp) begin failures++; $display("FAIL clamp_events got=%s exp=%s", ev_s, exp); end
        exp = expand_tx("0000000000111111111122222222223333333333", 1);
        checks++;
        if (idx_s != exp) begin failures++; $display("FAIL clamp_idx got=%s exp=%s", idx_s, exp); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL clamp_after got busy=%b tx=%b exp busy=0 tx=1", busy, tx_out);
        end
    endtask

    initial begin
        test_reset();
        test_wr_even();
        test_alu_odd_gap();
        test_no_parity();
        test_back_to_back();
        test_start_ignored();
        test_len_zero();
        test_reset_mid_frame();
        test_clamp_prescale0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
